// File: rtl/mem_responder.sv
// Word-addressed memory responder for MAR/MDR accesses.
// It accepts one request in IDLE, waits LATENCY cycles, then completes with a one-cycle ready pulse.
module mem_responder #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 9,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [31:0]       addr,
   input  logic              read_req,
   input  logic              write_req,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              mem_ready,
   output logic              mem_busy,
   output logic              mem_err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [3:0] LAT4 = 4'(LATENCY);

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic [3:0]        cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic              oor_q;
   logic              wr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              ready_q;
   logic              busy_q;
   logic              err_q;
   logic              in_oor;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   assign in_oor  = |addr[31:ADDR_W];
   assign cnt_d   = cnt_q + 4'd1;

   assign rd_data   = rd_data_q;
   assign mem_ready = ready_q;
   assign mem_busy  = busy_q;
   assign mem_err   = err_q;

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         rd_data_q <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (read_req ^ write_req) begin
                  addr_q  <= addr[ADDR_W-1:0];
                  oor_q   <= in_oor;
                  wr_q    <= write_req;
                  wdata_q <= wr_data;
                  cnt_q   <= 4'd0;
                  busy_q  <= 1'b1;
                  // Zero latency: the response register loads straight from the live inputs.
                  if (LATENCY == 0) begin
                     state_q <= RESP;
                     ready_q <= 1'b1;
                     err_q   <= in_oor;
                     if (read_req)
                        rd_data_q <= in_oor ? '0 : mem[addr[ADDR_W-1:0]];
                  end else begin
                     state_q <= WAIT;
                  end
               end else if (read_req && write_req) begin
                  ready_q <= 1'b1;
                  err_q   <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt_d == LAT4) begin
                  state_q <= RESP;
                  cnt_q   <= 4'd0;
                  ready_q <= 1'b1;
                  err_q   <= oor_q;
                  if (!wr_q)
                     rd_data_q <= oor_q ? '0 : mem[addr_q];
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Commit happens on the edge that leaves RESP, so a reset during RESP drops the write.
   always_ff @(posedge clk) begin
      if (clr && state_q == RESP && wr_q && !oor_q)
         mem[addr_q] <= wdata_q;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized bench for mem_responder against a word-array reference model.
// Instance u_a uses LATENCY=2 and instance u_z uses LATENCY=0.
module tb_mem_responder;

   logic        clk;
   logic        clr;
   logic [31:0] addr_a, wr_data_a, rd_data_a;
   logic        read_a, write_a, ready_a, busy_a, err_a;
   logic [31:0] addr_z, wr_data_z, rd_data_z;
   logic        read_z, write_z, ready_z, busy_z, err_z;

   int          total;
   int          passed;
   int          fails;
   logic [31:0] mem_m [512];
   logic [31:0] exp_rd;

   mem_responder #(.DATA_W(32), .ADDR_W(9), .LATENCY(2)) u_a (
      .clk(clk), .clr(clr), .addr(addr_a), .read_req(read_a), .write_req(write_a),
      .wr_data(wr_data_a), .rd_data(rd_data_a), .mem_ready(ready_a),
      .mem_busy(busy_a), .mem_err(err_a)
   );

   mem_responder #(.DATA_W(32), .ADDR_W(9), .LATENCY(0)) u_z (
      .clk(clk), .clr(clr), .addr(addr_z), .read_req(read_z), .write_req(write_z),
      .wr_data(wr_data_z), .rd_data(rd_data_z), .mem_ready(ready_z),
      .mem_busy(busy_z), .mem_err(err_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One access on the LATENCY=2 instance. Inputs are scrambled after accept to prove latching.
   task automatic op_a(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
      bit oor;
      oor = (a[31:9] != 23'd0);
      read_a = rd; write_a = wr; addr_a = a; wr_data_a = d;
      tick();
      read_a = 1'b0; write_a = 1'b0; addr_a = $urandom; wr_data_a = $urandom;
      if (rd && wr) begin
         chk("rej_ready", {31'd0, ready_a}, 32'd1);
         chk("rej_err",   {31'd0, err_a},   32'd1);
         chk("rej_busy",  {31'd0, busy_a},  32'd0);
         tick();
         chk("rej_ready_clr", {31'd0, ready_a}, 32'd0);
         chk("rej_err_clr",   {31'd0, err_a},   32'd0);
      end else if (rd || wr) begin
         for (int k = 1; k <= 3; k++) begin
            chk("busy",  {31'd0, busy_a},  32'd1);
            chk("ready", {31'd0, ready_a}, (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) begin
               chk("err", {31'd0, err_a}, oor ? 32'd1 : 32'd0);
               if (rd) exp_rd = oor ? 32'd0 : mem_m[a[8:0]];
               chk("rd_data", rd_data_a, exp_rd);
            end
            tick();
         end
         chk("busy_done",  {31'd0, busy_a},  32'd0);
         chk("ready_done", {31'd0, ready_a}, 32'd0);
         if (wr && !oor) mem_m[a[8:0]] = d;
      end
   endtask

   initial begin
      total = 0; passed = 0; fails = 0; exp_rd = 32'd0;
      clr = 1'b0;
      read_a = 0; write_a = 0; addr_a = 0; wr_data_a = 0;
      read_z = 0; write_z = 0; addr_z = 0; wr_data_z = 0;
      tick(); tick();
      chk("rst_rd",    rd_data_a, 32'd0);
      chk("rst_ready", {31'd0, ready_a}, 32'd0);
      chk("rst_busy",  {31'd0, busy_a},  32'd0);
      chk("rst_err",   {31'd0, err_a},   32'd0);
      chk("rst_busy_z", {31'd0, busy_z}, 32'd0);
      clr = 1'b1;
      tick();

      // Give addresses 0..15 known contents.
      for (int i = 0; i < 16; i++) op_a(1'b1, 1'b0, 32'(i), $urandom);

      op_a(1'b1, 1'b0, 32'd5, 32'hDEADBEEF);
      op_a(1'b0, 1'b1, 32'd5, 32'd0);
      chk("rd_after_write", rd_data_a, 32'hDEADBEEF);

      op_a(1'b1, 1'b1, 32'd5, 32'h0BAD0BAD);
      op_a(1'b0, 1'b1, 32'd5, 32'd0);

      op_a(1'b1, 1'b0, 32'h0000_0200, 32'h1234);
      op_a(1'b0, 1'b1, 32'd0, 32'd0);
      op_a(1'b0, 1'b1, 32'h0000_0200, 32'd0);
      chk("oor_rd_zero", rd_data_a, 32'd0);

      // Reset in WAIT aborts a pending write.
      write_a = 1'b1; addr_a = 32'd7; wr_data_a = 32'hCAFE;
      tick();
      write_a = 1'b0;
      chk("abort_busy_wait", {31'd0, busy_a}, 32'd1);
      clr = 1'b0;
      tick();
      exp_rd = 32'd0;
      chk("abort_ready", {31'd0, ready_a}, 32'd0);
      chk("abort_busy",  {31'd0, busy_a},  32'd0);
      chk("abort_err",   {31'd0, err_a},   32'd0);
      chk("abort_rd",    rd_data_a,        32'd0);
      clr = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("abort_no_ready", {31'd0, ready_a}, 32'd0);
      end
      op_a(1'b0, 1'b1, 32'd7, 32'd0);
      chk("abort_old", rd_data_a, mem_m[7]);

      for (int n = 0; n < 40; n++) begin
         int sel;
         logic [31:0] a;
         sel = $urandom_range(0, 9);
         a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_0200) : 32'($urandom_range(0, 15));
         if (sel == 0)      op_a(1'b1, 1'b1, a, $urandom);
         else if (sel < 5)  op_a(1'b1, 1'b0, a, $urandom);
         else               op_a(1'b0, 1'b1, a, 32'd0);
      end

      // Zero-latency instance: one write, then a continuously held read.
      write_z = 1'b1; addr_z = 32'd3; wr_data_z = 32'h5A5A_1234;
      tick();
      write_z = 1'b0;
      chk("z_wr_ready", {31'd0, ready_z}, 32'd1);
      chk("z_wr_busy",  {31'd0, busy_z},  32'd1);
      tick();
      chk("z_wr_idle", {31'd0, busy_z}, 32'd0);
      read_z = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("z_ready", {31'd0, ready_z}, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("z_busy",  {31'd0, busy_z},  (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("z_rd",    rd_data_z, 32'h5A5A_1234);
      end
      read_z = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
